accumulator_loader: RTL
=======================

// Module: accumulator_loader
// PURPOSE
//  Upstream feeder for the accumulator memory. Buffers operand words from a
//  source (testbench or host) in a small FIFO, then issues them one per
//  cycle on the nonzero-means-valid load bus consumed by the memory.
//  Stalls while the memory reports full, and stops after a programmed batch.
// PARAMETERS
//  WIDTH      32  operand/load bus width
//  DEPTH       8  FIFO entries (power of 2, 2..16)
//  NUM_WORDS  16  words issued per batch (1..255)
// PORTS
//  proc_clk      in   1      processor-domain clock, all logic on rising edge
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      source has a word on in_data
//  in_data       in   WIDTH  operand word
//  in_ready      out  1      loader accepts in_data this cycle
//  start         in   1      one-cycle pulse: begin or continue a batch
//  mem_full      in   1      memory cannot take a word; hold off issue
//  load_out      out  WIDTH  to memory load input; nonzero = one word valid
//  busy          out  1      state == LOAD
//  done          out  1      state == DONE
//  issued_count  out  8      words issued in the current batch
//  zero_drops    out  8      zero-valued words discarded, saturates at 255
// BEHAVIOUR
//  Reset: FIFO flushed, state IDLE. load_out=0, busy=0, done=0,
//   issued_count=0, zero_drops=0, in_ready=1. Reset mid-batch flushes all.
//  Input: in_ready = (fifo_count < DEPTH), from registered count, in every
//   state. Handshake completes when in_valid & in_ready.
//  Zero words: 0 cannot be expressed on the load bus. An accepted word of 0
//   is not written to the FIFO; zero_drops increments, saturating.
//  FSM IDLE -> LOAD on start. LOAD -> DONE on the edge that issues word
//   NUM_WORDS. DONE -> LOAD on start, clearing issued_count.
//   start is ignored in LOAD. FIFO contents persist across states.
//  Issue: in LOAD, when FIFO not empty and mem_full==0, pop the head and
//   register it onto load_out for exactly one cycle. issued_count += 1.
//   In all other cycles load_out = 0; it is never held two cycles.
//  mem_full is sampled the same cycle as the pop decision. While high: no
//   pop, load_out=0, and no word is lost or duplicated.
//  Latency: a word accepted at edge N appears on load_out during cycle N+2,
//   given LOAD state, mem_full=0 and an empty FIFO ahead of it.
//  Simultaneous push and pop: fifo_count unchanged; the word at the head is
//   issued, not the word being pushed. The FIFO is never bypassed.
//  Push when full cannot occur because in_ready=0 then.
//  Wrap-around: read and write pointers are log2(DEPTH) bits and wrap
//   naturally. fifo_count is a separate counter of log2(DEPTH)+1 bits.
//  busy/done are registered from state; done stays high until start/reset.
// TESTING
//  1 Reset held 2 cycles -> all outputs 0, in_ready=1; release, idle 5 cycles
//    -> load_out stays 0.
//  2 Push 3,5,7, pulse start -> load_out 3,5,7 on 3 consecutive cycles,
//    then 0; issued_count=3, busy=1.
//  3 Push 0 then 9, start -> zero_drops=1; only 9 issued; issued_count=1.
//  4 Push 8 words with no start -> in_ready=0 after the 8th; 9th held off
//    until start, then accepted once the first pop frees a slot.
//  5 Stream 1..6 with mem_full high 2 cycles mid-stream -> load_out=0 for
//    those 2 cycles; sequence resumes in order 1..6, none lost or repeated.
//  6 NUM_WORDS=4: push 10..15, start -> 10..13 issued, done=1, busy=0,
//    two words remain; start -> 14,15 issued, issued_count restarts at 1.

Source files
------------

// File: rtl/accumulator_loader.sv
// accumulator_loader
// Feeds operand words into the accumulator memory. Words from the source go
// into a small FIFO. While a batch is active, they are issued one per cycle
// on a load bus where a nonzero value means "one valid word". Issue pauses
// while the memory reports full, and the batch ends after NUM_WORDS words.
// A zero word cannot be shown on the load bus, so accepted zeros are counted
// and dropped instead of being queued.

module accumulator_loader #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_WORDS = 16
) (
  input  logic             proc_clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             start,
  input  logic             mem_full,
  output logic [WIDTH-1:0] load_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       issued_count,
  output logic [7:0]       zero_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_load;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_issued;
  logic [7:0]       r_zero_drops;

  logic w_accept;
  logic w_push;
  logic w_zero;
  logic w_pop;
  logic w_last;
  logic w_clear_issued;

  // in_ready comes straight from the registered occupancy, in every state.
  assign in_ready = (r_count < FULL_CNT);

  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & (in_data != {WIDTH{1'b0}});
  assign w_zero   = w_accept & (in_data == {WIDTH{1'b0}});
  // A pop takes the head only. A word pushed in the same cycle is never bypassed.
  assign w_pop    = (r_state == ST_LOAD) & (r_count != {(AW+1){1'b0}}) & ~mem_full;
  assign w_last   = w_pop & (r_issued == LAST_IDX);

  assign load_out     = r_load;
  assign busy         = r_busy;
  assign done         = r_done;
  assign issued_count = r_issued;
  assign zero_drops   = r_zero_drops;

  // Next-state logic for the batch controller; start is ignored while loading.
  always_comb begin
    w_state_next   = r_state;
    w_clear_issued = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_LOAD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_LOAD;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_next   = ST_LOAD;
          w_clear_issued = 1'b1;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register, plus busy/done registered to match the state they flag.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_LOAD);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  // FIFO storage. No reset is needed because reset flushes the pointers.
  always_ff @(posedge proc_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // FIFO pointers wrap naturally; occupancy is kept as a separate counter.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Load bus: a popped word is shown for exactly one cycle, otherwise zero.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_load <= {WIDTH{1'b0}};
    end else if (w_pop) begin
      r_load <= r_mem[r_rptr];
    end else begin
      r_load <= {WIDTH{1'b0}};
    end
  end

  // Count of words issued in the current batch; it restarts when DONE is left.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_issued <= 8'd0;
    end else if (w_clear_issued) begin
      r_issued <= 8'd0;
    end else if (w_pop) begin
      r_issued <= r_issued + 8'd1;
    end
  end

  // Saturating count of zero words that were accepted and then discarded.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_zero_drops <= 8'd0;
    end else if (w_zero && (r_zero_drops != 8'hFF)) begin
      r_zero_drops <= r_zero_drops + 8'd1;
    end
  end

endmodule
